// File: rtl/aq_djpeg_feeder.sv
// Byte-stream to 32-bit word feeder for the JPEG decoder input port.
// Packs bytes big-endian, buffers words in a FWFT FIFO and keeps fill/byte/stall statistics.
module aq_djpeg_feeder #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  FeedFlush,
    output logic [31:0]           DataIn,
    output logic                  DataInEnable,
    input  logic                  DataInRead,
    input  logic                  DataInReq,
    output logic                  DataInLast,
    output logic [DEPTH_LOG2:0]   FifoLevel,
    output logic [31:0]           ByteCount,
    output logic [15:0]           StallCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [32:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    level;
    logic [1:0]             idx;
    logic [31:0]            pack_word;
    logic                   running;

    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] pack_next;
    logic [31:0] commit_word;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);

    // running holds s_tready low while in reset so every output reads 0 there
    assign s_tready = running && !FeedFlush && !fifo_full;
    assign accept   = s_tvalid && s_tready;
    assign push     = accept && ((idx == 2'd3) || s_tlast);
    assign pop      = DataInRead && !fifo_empty && !FeedFlush;

    assign DataInEnable = !fifo_empty;
    assign DataIn       = fifo_empty ? 32'h0 : mem[rd_ptr][31:0];
    assign DataInLast   = fifo_empty ? 1'b0  : mem[rd_ptr][32];
    assign FifoLevel    = level;

    // Lane 0 is the MSB byte; lanes past the current byte get padding on commit
    always_comb begin
        pack_next   = pack_word;
        commit_word = pack_word;
        for (int l = 0; l < 4; l++) begin
            if (l == int'(idx)) begin
                pack_next[31-8*l -: 8]   = s_tdata;
                commit_word[31-8*l -: 8] = s_tdata;
            end else if (l > int'(idx)) begin
                commit_word[31-8*l -: 8] = PAD_BYTE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_tlast, commit_word};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running    <= 1'b0;
            idx        <= 2'd0;
            pack_word  <= 32'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ByteCount  <= 32'h0;
            StallCount <= 16'h0;
        end else begin
            running <= 1'b1;
            if (FeedFlush) begin
                idx        <= 2'd0;
                pack_word  <= 32'h0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
                ByteCount  <= 32'h0;
                StallCount <= 16'h0;
            end else begin
                if (accept) begin
                    ByteCount <= ByteCount + 32'd1;
                    if (push) begin
                        idx       <= 2'd0;
                        pack_word <= 32'h0;
                    end else begin
                        idx       <= idx + 2'd1;
                        pack_word <= pack_next;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
                if (DataInReq && fifo_empty && (StallCount != 16'hFFFF)) begin
                    StallCount <= StallCount + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aq_djpeg_feeder.sv
// Directed bench for aq_djpeg_feeder: vector table for packing/pop basics,
// hand sequences for full FIFO, stall/flush and asynchronous reset.
module tb_aq_djpeg_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        FeedFlush;
    logic [31:0] DataIn;
    logic        DataInEnable;
    logic        DataInRead;
    logic        DataInReq;
    logic        DataInLast;
    logic [4:0]  FifoLevel;
    logic [31:0] ByteCount;
    logic [15:0] StallCount;

    int checks   = 0;
    int failures = 0;

    aq_djpeg_feeder #(.DEPTH_LOG2(4), .PAD_BYTE(8'hFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tlast      (s_tlast),
        .FeedFlush    (FeedFlush),
        .DataIn       (DataIn),
        .DataInEnable (DataInEnable),
        .DataInRead   (DataInRead),
        .DataInReq    (DataInReq),
        .DataInLast   (DataInLast),
        .FifoLevel    (FifoLevel),
        .ByteCount    (ByteCount),
        .StallCount   (StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        last;
        logic        read;
        logic        req;
        logic [31:0] exp_data;
        logic        exp_en;
        logic        exp_last;
        logic [4:0]  exp_level;
        logic [31:0] exp_bytes;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic read_word();
        DataInRead = 1'b1;
        step();
        DataInRead = 1'b0;
    endtask

    task automatic flush_pulse();
        FeedFlush = 1'b1;
        #1;
        check("flush_tready", 32'(s_tready), 32'd0);
        step();
        FeedFlush = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] exp;
        logic        got_ready;

        rst        = 1'b0;
        s_tdata    = 8'h00;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        FeedFlush  = 1'b0;
        DataInRead = 1'b0;
        DataInReq  = 1'b0;

        // Vector table: packing, padding, last flag, pops and simultaneous push/pop
        vecs[0]  = '{8'hFF, 1, 0, 0, 0, 32'h00000000, 0, 0, 5'd0, 32'd1,  16'd0};
        vecs[1]  = '{8'hD8, 1, 0, 0, 0, 32'h00000000, 0, 0, 5'd0, 32'd2,  16'd0};
        vecs[2]  = '{8'hFF, 1, 0, 0, 0, 32'h00000000, 0, 0, 5'd0, 32'd3,  16'd0};
        vecs[3]  = '{8'hE0, 1, 0, 0, 0, 32'hFFD8FFE0, 1, 0, 5'd1, 32'd4,  16'd0};
        vecs[4]  = '{8'h11, 1, 0, 0, 0, 32'hFFD8FFE0, 1, 0, 5'd1, 32'd5,  16'd0};
        vecs[5]  = '{8'h22, 1, 0, 0, 0, 32'hFFD8FFE0, 1, 0, 5'd1, 32'd6,  16'd0};
        vecs[6]  = '{8'h33, 1, 1, 0, 0, 32'hFFD8FFE0, 1, 0, 5'd2, 32'd7,  16'd0};
        vecs[7]  = '{8'h00, 0, 0, 1, 0, 32'h112233FF, 1, 1, 5'd1, 32'd7,  16'd0};
        vecs[8]  = '{8'hD9, 1, 1, 1, 0, 32'hD9FFFFFF, 1, 1, 5'd1, 32'd8,  16'd0};
        vecs[9]  = '{8'h00, 0, 0, 1, 0, 32'h00000000, 0, 0, 5'd0, 32'd8,  16'd0};
        vecs[10] = '{8'hA0, 1, 0, 1, 0, 32'h00000000, 0, 0, 5'd0, 32'd9,  16'd0};
        vecs[11] = '{8'hA1, 1, 0, 0, 0, 32'h00000000, 0, 0, 5'd0, 32'd10, 16'd0};
        vecs[12] = '{8'hA2, 1, 0, 0, 0, 32'h00000000, 0, 0, 5'd0, 32'd11, 16'd0};
        vecs[13] = '{8'hA3, 1, 0, 0, 0, 32'hA0A1A2A3, 1, 0, 5'd1, 32'd12, 16'd0};
        vecs[14] = '{8'hB0, 1, 0, 0, 0, 32'hA0A1A2A3, 1, 0, 5'd1, 32'd13, 16'd0};
        vecs[15] = '{8'hB1, 1, 0, 0, 0, 32'hA0A1A2A3, 1, 0, 5'd1, 32'd14, 16'd0};
        vecs[16] = '{8'hB2, 1, 0, 0, 0, 32'hA0A1A2A3, 1, 0, 5'd1, 32'd15, 16'd0};
        vecs[17] = '{8'hB3, 1, 0, 1, 0, 32'hB0B1B2B3, 1, 0, 5'd1, 32'd16, 16'd0};
        vecs[18] = '{8'h00, 0, 0, 1, 0, 32'h00000000, 0, 0, 5'd0, 32'd16, 16'd0};
        vecs[19] = '{8'h00, 0, 0, 0, 1, 32'h00000000, 0, 0, 5'd0, 32'd16, 16'd1};
        vecs[20] = '{8'h00, 0, 0, 0, 1, 32'h00000000, 0, 0, 5'd0, 32'd16, 16'd2};

        // Reset state
        #12;
        check("rst_data",   DataIn, 32'h0);
        check("rst_en",     32'(DataInEnable), 32'd0);
        check("rst_level",  32'(FifoLevel), 32'd0);
        check("rst_bytes",  ByteCount, 32'd0);
        check("rst_stall",  32'(StallCount), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        rst = 1'b1;
        step();
        check("run_tready", 32'(s_tready), 32'd1);

        for (int i = 0; i < 21; i++) begin
            s_tdata    = vecs[i].data;
            s_tvalid   = vecs[i].valid;
            s_tlast    = vecs[i].last;
            DataInRead = vecs[i].read;
            DataInReq  = vecs[i].req;
            step();
            check($sformatf("v%0d_data", i),  DataIn, vecs[i].exp_data);
            check($sformatf("v%0d_en", i),    32'(DataInEnable), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_last", i),  32'(DataInLast), 32'(vecs[i].exp_last));
            check($sformatf("v%0d_level", i), 32'(FifoLevel), 32'(vecs[i].exp_level));
            check($sformatf("v%0d_bytes", i), ByteCount, vecs[i].exp_bytes);
            check($sformatf("v%0d_stall", i), 32'(StallCount), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d_tready", i), 32'(s_tready), 32'd1);
        end
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        DataInRead = 1'b0;
        DataInReq  = 1'b0;

        // Fill FIFO to capacity, then one read reopens it
        flush_pulse();
        check("fl_stall", 32'(StallCount), 32'd0);
        for (int k = 0; k < 64; k++) begin
            push_byte(8'(k), 1'b0);
        end
        check("full_level",  32'(FifoLevel), 32'd16);
        check("full_tready", 32'(s_tready), 32'd0);
        check("full_bytes",  ByteCount, 32'd64);
        check("full_head",   DataIn, 32'h00010203);
        read_word();
        check("unfull_level",  32'(FifoLevel), 32'd15);
        check("unfull_tready", 32'(s_tready), 32'd1);
        check("unfull_head",   DataIn, 32'h04050607);
        for (int k = 1; k < 16; k++) begin
            exp = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            check($sformatf("drain%0d", k), DataIn, exp);
            read_word();
        end
        check("drained_level", 32'(FifoLevel), 32'd0);
        check("drained_en",    32'(DataInEnable), 32'd0);

        // Starvation count, then flush with buffered and partial data
        DataInReq = 1'b1;
        repeat (10) step();
        DataInReq = 1'b0;
        check("stall10", 32'(StallCount), 32'd10);
        for (int k = 0; k < 10; k++) begin
            push_byte(8'(8'h40 + k), 1'b0);
        end
        check("pre_flush_level", 32'(FifoLevel), 32'd2);
        s_tdata  = 8'h77;
        s_tvalid = 1'b1;
        flush_pulse();
        s_tvalid = 1'b0;
        check("flush_level", 32'(FifoLevel), 32'd0);
        check("flush_bytes", ByteCount, 32'd0);
        check("flush_stall", 32'(StallCount), 32'd0);
        check("flush_en",    32'(DataInEnable), 32'd0);
        check("flush_data",  DataIn, 32'h0);
        push_byte(8'h5A, 1'b1);
        check("post_flush_data",  DataIn, 32'h5AFFFFFF);
        check("post_flush_last",  32'(DataInLast), 32'd1);
        check("post_flush_bytes", ByteCount, 32'd1);
        read_word();

        // Asynchronous reset between edges with three words stored
        for (int k = 0; k < 12; k++) begin
            push_byte(8'(8'h90 + k), 1'b0);
        end
        check("pre_rst_level", 32'(FifoLevel), 32'd3);
        #3;
        rst = 1'b0;
        #1;
        check("arst_data",   DataIn, 32'h0);
        check("arst_en",     32'(DataInEnable), 32'd0);
        check("arst_level",  32'(FifoLevel), 32'd0);
        check("arst_bytes",  ByteCount, 32'd0);
        check("arst_tready", 32'(s_tready), 32'd0);
        #2;
        rst = 1'b1;
        got_ready = 1'b0;
        for (int t = 0; t < 5 && !got_ready; t++) begin
            step();
            got_ready = s_tready;
        end
        check("rel_tready", 32'(got_ready), 32'd1);
        push_byte(8'hC1, 1'b0);
        push_byte(8'hC2, 1'b0);
        push_byte(8'hC3, 1'b0);
        push_byte(8'hC4, 1'b0);
        check("rel_data",  DataIn, 32'hC1C2C3C4);
        check("rel_level", 32'(FifoLevel), 32'd1);
        check("rel_bytes", ByteCount, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
